// File: rtl/instr_encoder_loader.sv
// -----------------------------------------------------------------------------
// instr_encoder_loader
// Purpose : This block does the reverse of the main control decoder. It packs
//           a mnemonic code and its operand fields into a 32-bit MIPS
//           instruction word. Each accepted word is written to instruction
//           memory at the next sequential address.
//           It covers exactly the subset that the single-cycle core decodes.
//
// Ports   :
//   clk        in   1         clock, rising edge
//   rst_n      in   1         asynchronous active-low reset
//   clear      in   1         synchronous restart: count/full/state cleared
//   req_valid  in   1         request present
//   req_ready  out  1         block can accept a request
//   mnem       in   5         mnemonic code (27..31 illegal)
//   rs,rt,rd   in   5         register fields
//   shamt      in   5         shift amount (sll/srl/sra)
//   imm16      in   16        immediate / offset
//   target     in   26        jump target
//   imem_we    out  1         one-cycle write strobe
//   imem_addr  out  32        BASE_ADDR + 4*count
//   imem_wdata out  32        encoded word (holds when imem_we=0)
//   count      out  ADDR_W+1  words written since reset/clear
//   full       out  1         count == 2**ADDR_W
//   err        out  1         pulse: illegal mnem accepted or request while full
//
// State table
//   state | meaning
//   IDLE  | waiting for a request; ready when not full
//   WRITE | registered word is presented to memory with imem_we=1
// -----------------------------------------------------------------------------
module instr_encoder_loader #(
    parameter int unsigned ADDR_W    = 8,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [4:0]        mnem,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [4:0]        shamt,
    input  logic [15:0]       imm16,
    input  logic [25:0]       target,
    output logic              imem_we,
    output logic [31:0]       imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              err
);

    localparam int unsigned     CAP_I = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] CAP   = CAP_I[ADDR_W:0];

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W:0]   r_count;
    logic              r_full;
    logic              r_err;
    logic [31:0]       r_wdata;

    logic              w_hs;
    logic              w_legal;
    logic [31:0]       w_word;
    logic [5:0]        w_op;
    logic [5:0]        w_funct;
    logic [4:0]        w_rs;
    logic [4:0]        w_rt;
    logic [4:0]        w_rd;
    logic [4:0]        w_sh;
    logic [ADDR_W:0]   w_count_inc;

    // ---------------------------------------------------------------------
    // Encoder
    // ---------------------------------------------------------------------
    always_comb begin
        w_legal = 1'b1;
        w_op    = 6'h00;
        w_funct = 6'h00;
        w_rs    = rs;
        w_rt    = rt;
        w_rd    = rd;
        w_sh    = 5'd0;
        w_word  = 32'h0;
        case (mnem)
            5'd0:  w_funct = 6'h00;
            5'd1:  w_funct = 6'h02;
            5'd2:  w_funct = 6'h03;
            5'd3:  w_funct = 6'h04;
            5'd4:  w_funct = 6'h06;
            5'd5:  w_funct = 6'h08;
            5'd6:  w_funct = 6'h20;
            5'd7:  w_funct = 6'h22;
            5'd8:  w_funct = 6'h24;
            5'd9:  w_funct = 6'h25;
            5'd10: w_funct = 6'h26;
            5'd11: w_funct = 6'h27;
            5'd12: w_funct = 6'h2A;
            5'd13: w_funct = 6'h2B;
            5'd14: w_op    = 6'b000010;
            5'd15: w_op    = 6'b000011;
            5'd16: w_op    = 6'b001000;
            5'd17: w_op    = 6'b001010;
            5'd18: w_op    = 6'b001011;
            5'd19: w_op    = 6'b001100;
            5'd20: w_op    = 6'b001101;
            5'd21: w_op    = 6'b001110;
            5'd22: w_op    = 6'b001111;
            5'd23: w_op    = 6'b100011;
            5'd24: w_op    = 6'b101011;
            5'd25: w_op    = 6'b000100;
            5'd26: w_op    = 6'b000101;
            default: w_legal = 1'b0;
        endcase

        // Only the three constant shifts carry a shift amount.
        if (mnem <= 5'd2) begin
            w_sh = shamt;
        end
        if (mnem == 5'd5) begin
            w_rt = 5'd0;
            w_rd = 5'd0;
        end
        if (mnem == 5'd22) begin
            w_rs = 5'd0;
        end

        if (mnem <= 5'd13) begin
            w_word = {6'h00, w_rs, w_rt, w_rd, w_sh, w_funct};
        end else if (mnem <= 5'd15) begin
            w_word = {w_op, target};
        end else if (w_legal) begin
            w_word = {w_op, w_rs, w_rt, imm16};
        end
    end

    // ---------------------------------------------------------------------
    // FSM
    // ---------------------------------------------------------------------
    assign req_ready = (r_state == IDLE) && !r_full;
    // A clear in the handshake cycle overrides the request.
    assign w_hs      = req_valid && req_ready && !clear;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (clear) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (w_hs && w_legal) w_state_nxt = WRITE;
                WRITE:   w_state_nxt = IDLE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // Datapath registers
    // ---------------------------------------------------------------------
    assign w_count_inc = r_count + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_full  <= 1'b0;
            r_err   <= 1'b0;
            r_wdata <= 32'h0;
        end else if (clear) begin
            r_count <= '0;
            r_full  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_err <= (w_hs && !w_legal) || (req_valid && r_full);
            if (w_hs && w_legal) begin
                r_wdata <= w_word;
            end
            if (r_state == WRITE) begin
                r_count <= w_count_inc;
                r_full  <= (w_count_inc == CAP);
            end
        end
    end

    // The strobe is gated by clear so that a clear in the WRITE cycle drops the write.
    assign imem_we    = (r_state == WRITE) && !clear;
    assign imem_addr  = BASE_ADDR + (32'(r_count) << 2);
    assign imem_wdata = r_wdata;
    assign count      = r_count;
    assign full       = r_full;
    assign err        = r_err;

endmodule
